// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Operands are taken on a start/ready handshake; results and flags land together on done.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             borrow_q;
  logic             a_msb_q, b_msb_q;
  logic             ready_q, done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q, overflow_q, zero_q;

  logic ai, bi, bit_d, borrow_d;

  // Full-subtract of the current LSB pair against the registered borrow.
  always_comb begin
    ai       = a_q[0];
    bi       = b_q[0];
    bit_d    = ai ^ bi ^ borrow_q;
    borrow_d = (~ai & bi) | (~(ai ^ bi) & borrow_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            a_msb_q  <= a_i[WIDTH-1];
            b_msb_q  <= b_i[WIDTH-1];
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            ready_q  <= 1'b0;
            state_q  <= StShift;
          end
        end
        StShift: begin
          if (cnt_q == LastCnt) begin
            // All bits processed: publish the full result at once.
            diff_q       <= res_q;
            borrow_out_q <= borrow_q;
            overflow_q   <= (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
            zero_q       <= (res_q == '0);
            done_q       <= 1'b1;
            state_q      <= StDone;
          end else begin
            res_q    <= {bit_d, res_q[WIDTH-1:1]};
            a_q      <= a_q >> 1;
            b_q      <= b_q >> 1;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ready_o      = ready_q;
    done_o       = done_q;
    diff_o       = diff_q;
    borrow_out_o = borrow_out_q;
    overflow_o   = overflow_q;
    zero_o       = zero_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, done8, borrow8, ovf8, zero8;
  logic [7:0]  diff8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16, done16, borrow16, ovf16, zero16;
  logic [15:0] diff16;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
    .ready_o(ready8), .done_o(done8), .diff_o(diff8),
    .borrow_out_o(borrow8), .overflow_o(ovf8), .zero_o(zero8)
  );

  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .a_i(a16), .b_i(b16),
    .ready_o(ready16), .done_o(done16), .diff_o(diff16),
    .borrow_out_o(borrow16), .overflow_o(ovf16), .zero_o(zero16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one 8-bit op from IDLE; lat = edges after the accepting edge until done is seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
    start8 = 1'b1; a8 = a; b8 = b;
    step();
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    rst = 1'b0;
    checks++;
    if ({ready8, done8, diff8, borrow8, ovf8, zero8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset8: got rdy=%b done=%b diff=%h b=%b o=%b z=%b, want 1 0 00 0 0 0",
               ready8, done8, diff8, borrow8, ovf8, zero8);
    end
    checks++;
    if ({ready16, done16, diff16, borrow16, ovf16, zero16} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset16: got rdy=%b done=%b diff=%h, want 1 0 0000", ready16, done16, diff16);
    end
  endtask

  task automatic test_basic();
    int lat;
    run8(8'd100, 8'd37, lat);
    checks++;
    if (lat != 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 9", lat);
    end
    checks++;
    if ({diff8, borrow8, ovf8, zero8} !== {8'h3F, 3'b000}) begin
      errors++;
      $display("FAIL basic_result: got diff=%h b=%b o=%b z=%b, want 3f 0 0 0",
               diff8, borrow8, ovf8, zero8);
    end
    step();
    checks++;
    if ({done8, ready8, diff8} !== {1'b0, 1'b1, 8'h3F}) begin
      errors++;
      $display("FAIL basic_after_done: got done=%b rdy=%b diff=%h, want 0 1 3f",
               done8, ready8, diff8);
    end
  endtask

  task automatic test_flags();
    logic [7:0] va [4] = '{8'h05, 8'h5A, 8'h80, 8'h7F};
    logic [7:0] vb [4] = '{8'h0A, 8'h5A, 8'h01, 8'hFF};
    logic [7:0] vd [4] = '{8'hFB, 8'h00, 8'h7F, 8'h80};
    logic [2:0] vf [4] = '{3'b100, 3'b001, 3'b010, 3'b110};  // {borrow, overflow, zero}
    int lat;
    for (int i = 0; i < 4; i++) begin
      run8(va[i], vb[i], lat);
      checks++;
      if (lat != 9 || {diff8, borrow8, ovf8, zero8} !== {vd[i], vf[i]}) begin
        errors++;
        $display("FAIL flags[%0d]: got lat=%0d diff=%h bof=%b%b%b, want lat=9 diff=%h bof=%b",
                 i, lat, diff8, borrow8, ovf8, zero8, vd[i], vf[i]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen = 0;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11;
    step();
    start8 = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({ready8, done8, diff8, borrow8, ovf8, zero8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b done=%b diff=%h b=%b o=%b z=%b, want 1 0 00 0 0 0",
               ready8, done8, diff8, borrow8, ovf8, zero8);
    end
    repeat (15) begin
      step();
      if (done8 === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_done: got done pulse, want none");
    end
    run8(8'h10, 8'h01, lat);
    checks++;
    if (lat != 9 || diff8 !== 8'h0F) begin
      errors++;
      $display("FAIL reset_mid_next: got lat=%0d diff=%h, want lat=9 diff=0f", lat, diff8);
    end
    step();
  endtask

  task automatic test_ignore_start();
    bit bad = 0;
    start8 = 1'b1; a8 = 8'h30; b8 = 8'h10;
    step();
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
    checks++;
    if (diff8 !== 8'h0F) begin
      errors++;
      $display("FAIL start_keeps_diff: got %h, want 0f", diff8);
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (ready8 !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready[E%0d]: got %b, want 0", k, ready8);
      end
      checks++;
      if (k < 9 && {done8, diff8} !== {1'b0, 8'h0F}) begin
        errors++;
        $display("FAIL no_partial[E%0d]: got done=%b diff=%h, want 0 0f", k, done8, diff8);
      end else if (k == 9 && {done8, diff8} !== {1'b1, 8'h20}) begin
        errors++;
        $display("FAIL ignore_result: got done=%b diff=%h, want 1 20", done8, diff8);
      end
      start8 = (k == 2 || k == 9);
    end
    step();
    start8 = 1'b0;
    checks++;
    if ({ready8, done8, diff8} !== {1'b1, 1'b0, 8'h20}) begin
      errors++;
      $display("FAIL ignore_idle: got rdy=%b done=%b diff=%h, want 1 0 20", ready8, done8, diff8);
    end
    repeat (4) begin
      step();
      if (ready8 !== 1'b1 || done8 !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ignore_no_queue: got a queued operation, want none");
    end
  endtask

  task automatic test_rst_start();
    bit bad = 0;
    rst = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    step();
    rst = 1'b0; start8 = 1'b0;
    checks++;
    if ({ready8, done8, diff8} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rst_start: got rdy=%b done=%b diff=%h, want 1 0 00", ready8, done8, diff8);
    end
    repeat (12) begin
      step();
      if (ready8 !== 1'b1 || done8 !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_start_dropped: got an operation, want none");
    end
  endtask

  task automatic test_wide();
    int lat = 0;
    start16 = 1'b1; a16 = 16'h0000; b16 = 16'h0001;
    step();
    start16 = 1'b0; a16 = 16'h5555; b16 = 16'hAAAA;
    while (done16 !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    checks++;
    if (lat != 17 || {diff16, borrow16, ovf16, zero16} !== {16'hFFFF, 3'b100}) begin
      errors++;
      $display("FAIL wide: got lat=%0d diff=%h b=%b o=%b z=%b, want lat=17 ffff 1 0 0",
               lat, diff16, borrow16, ovf16, zero16);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea, eb, ed;
    logic [16:0] full;
    logic [2:0]  ef;
    int w, lat;
    start16 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      w = 0;
      while (ready16 !== 1'b1 && w < 40) begin
        step();
        w++;
      end
      checks++;
      if (w >= 40 || (i > 0 && w != 1)) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got wait=%0d, want 1", i, w);
        if (w >= 40) break;
      end
      ea = 16'($urandom);
      eb = (i % 8 == 0) ? ea : 16'($urandom);
      a16 = ea; b16 = eb;
      step();
      a16 = 16'($urandom); b16 = 16'($urandom);
      lat = 0;
      while (done16 !== 1'b1 && lat < 60) begin
        step();
        lat++;
      end
      full = {1'b0, ea} - {1'b0, eb};
      ed   = full[15:0];
      ef   = {full[16], (ea[15] != eb[15]) && (ed[15] != ea[15]), ed == 16'h0};
      checks++;
      if (lat != 17 || {diff16, borrow16, ovf16, zero16} !== {ed, ef}) begin
        errors++;
        $display("FAIL b2b[%0d] %h-%h: got lat=%0d diff=%h bof=%b%b%b, want lat=17 %h %b",
                 i, ea, eb, lat, diff16, borrow16, ovf16, zero16, ed, ef);
        if (lat >= 60) break;
      end
    end
    start16 = 1'b0;
    repeat (20) step();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_flags();
    test_reset_mid();
    test_ignore_start();
    test_rst_start();
    test_wide();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
